saber_cmov: RTL

- Constant-time conditional move stage that sits directly downstream of the ciphertext-verify stage in Saber decapsulation.
- Consumes the verify result: when the re-encrypted ciphertext matches, copies the candidate key K' to the destination buffer; otherwise copies the rejection secret z.
- Always reads both sources, always writes every word, and takes a fixed cycle count, so neither timing nor access pattern depends on the verify result.

---
 rtl/saber_cmov_pkg.sv | 19 +
 rtl/ct_select64.sv | 13 +
 rtl/saber_cmov.sv | 104 ++++++++++
 3 files changed

// File: rtl/saber_cmov_pkg.sv
// rtl/saber_cmov_pkg.sv - shared state, bank and width constants for the constant-time key move
package saber_cmov_pkg;

   localparam int WORD_W = 64;
   localparam int ADDR_W = 9;

   localparam logic BANK_KP = 1'b0;
   localparam logic BANK_Z  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD_A  = 3'd1,
      ST_RD_B  = 3'd2,
      ST_CAP_B = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/ct_select64.sv
// rtl/ct_select64.sv - branch-free masked select, out = a where mask is 1, b elsewhere
module ct_select64
   import saber_cmov_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic [WORD_W-1:0] mask,
   output logic [WORD_W-1:0] out
);

   assign out = (a & mask) | (b & ~mask);

endmodule

// File: rtl/saber_cmov.sv
// rtl/saber_cmov.sv - fixed-latency K'/z conditional move; CMOV_SCRUB_EN clears wa/wb/mask on entry to DONE
module saber_cmov
   import saber_cmov_pkg::*;
#(
   parameter int                LEN       = 4,
   parameter logic [ADDR_W-1:0] RD_OFFSET = 9'd0,
   parameter logic [ADDR_W-1:0] WR_OFFSET = 9'd0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              verify_true,
   output logic [ADDR_W-1:0] rd_address,
   output logic              rd_base_sel,
   input  logic [WORD_W-1:0] din,
   output logic [ADDR_W-1:0] wr_address,
   output logic              wr_en,
   output logic [WORD_W-1:0] dout,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LEN - 1);

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic [WORD_W-1:0] mask;
   logic [WORD_W-1:0] wa;
   logic [WORD_W-1:0] wb;
   logic [WORD_W-1:0] sel;
   logic              armed;

   ct_select64 u_sel (
      .a    (wa),
      .b    (wb),
      .mask (mask),
      .out  (sel)
   );

   // Gating with the write strobe keeps dout at zero outside WRITE without a branch on mask.
   assign dout = sel & {WORD_W{wr_en}};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         idx         <= '0;
         mask        <= '0;
         wa          <= '0;
         wb          <= '0;
         armed       <= 1'b0;
         rd_address  <= '0;
         rd_base_sel <= BANK_KP;
         wr_address  <= '0;
         wr_en       <= 1'b0;
         done        <= 1'b0;
      end else begin
         // armed stays low for the first edge after reset so a start coincident with release is dropped
         armed       <= 1'b1;
         wr_en       <= 1'b0;
         rd_base_sel <= BANK_KP;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start && armed) begin
                  state      <= ST_RD_A;
                  idx        <= '0;
                  mask       <= {WORD_W{verify_true}};
                  done       <= 1'b0;
                  rd_address <= RD_OFFSET;
               end
            end
            ST_RD_A: begin
               state       <= ST_RD_B;
               rd_base_sel <= BANK_Z;
            end
            ST_RD_B: begin
               state <= ST_CAP_B;
               wa    <= din;
            end
            ST_CAP_B: begin
               state      <= ST_WRITE;
               wb         <= din;
               wr_en      <= 1'b1;
               wr_address <= WR_OFFSET + idx;
            end
            ST_WRITE: begin
               if (idx == LAST) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
`ifdef CMOV_SCRUB_EN
                  wa    <= '0;
                  wb    <= '0;
                  mask  <= '0;
`endif
               end else begin
                  state      <= ST_RD_A;
                  idx        <= idx + ADDR_W'(1);
                  rd_address <= RD_OFFSET + idx + ADDR_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
